// File: rtl/rf_pkg.sv
// Shared sizing constants for the register-file operand-fetch slice.
package rf_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int ZERO_REG = 0;

endpackage : rf_pkg

// File: rtl/rf_scoreboard.sv
// Busy-register scoreboard: one pending bit per architectural register, with
// the writeback clear and issue set applied together (set wins on a collision).
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W = rf_pkg::ADDR_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_en_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic [ADDR_W-1:0] look_a_i,
    input  logic [ADDR_W-1:0] look_b_i,
    input  logic [ADDR_W-1:0] look_d_i,
    output logic              pend_a_o,
    output logic              pend_b_o,
    output logic              pend_d_o
);

    localparam int N_REGS = 2 ** ADDR_W;

    logic [N_REGS-1:0] busy_q;
    logic [N_REGS-1:0] busy_d;

    // NOTE: every always_comb output starts from a full default so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignment only, so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A register retiring this very cycle is not pending: its data is on the bypass.
    assign pend_a_o = busy_q[look_a_i] & ~(clr_en_i & (clr_addr_i == look_a_i));
    assign pend_b_o = busy_q[look_b_i] & ~(clr_en_i & (clr_addr_i == look_b_i));
    assign pend_d_o = busy_q[look_d_i] & ~(clr_en_i & (clr_addr_i == look_d_i));

endmodule : rf_scoreboard

// File: rtl/rf_operand_fetch.sv
// Operand-fetch / writeback front end: drives the RF ports, bypasses same-cycle
// writeback data, stalls on pending writes and registers operands for execute.
module rf_operand_fetch
    import rf_pkg::*;
#(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [ADDR_W-1:0] InRs,
    input  logic [ADDR_W-1:0] InRt,
    input  logic [ADDR_W-1:0] InRd,
    input  logic              InRdWr,
    output logic [ADDR_W-1:0] Ard1,
    output logic [ADDR_W-1:0] Ard2,
    input  logic [DATA_W-1:0] Dout1,
    input  logic [DATA_W-1:0] Dout2,
    input  logic              WbValid,
    input  logic [ADDR_W-1:0] WbAddr,
    input  logic [DATA_W-1:0] WbData,
    output logic [ADDR_W-1:0] Awr,
    output logic [DATA_W-1:0] Din,
    output logic              WrEn,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutOpA,
    output logic [DATA_W-1:0] OutOpB,
    output logic [ADDR_W-1:0] OutRd,
    output logic              OutRdWr
);

    logic              pend_a, pend_b, pend_d;
    logic              hazard, accept, set_en;
    logic [DATA_W-1:0] op_a, op_b;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic              rdwr_q, rdwr_d;

    assign Ard1 = InRs;
    assign Ard2 = InRt;
    assign Awr  = WbAddr;
    assign Din  = WbData;
    assign WrEn = WbValid & ~Reset;

    rf_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
        .clk_i      (Clk),
        .reset_i    (Reset),
        .set_en_i   (set_en),
        .set_addr_i (InRd),
        .clr_en_i   (WbValid),
        .clr_addr_i (WbAddr),
        .look_a_i   (InRs),
        .look_b_i   (InRt),
        .look_d_i   (InRd),
        .pend_a_o   (pend_a),
        .pend_b_o   (pend_b),
        .pend_d_o   (pend_d)
    );

    assign hazard  = InValid & (pend_a | pend_b | (InRdWr & pend_d));
    assign InReady = (~OutValid | OutReady) & ~hazard & ~Reset;
    assign accept  = InValid & InReady;
    assign set_en  = accept & InRdWr & (InRd != ADDR_W'(ZERO_REG));

    // Register 0 beats the bypass, the bypass beats the (not yet written) RF.
    function automatic logic [DATA_W-1:0] pick_operand(
        input logic [ADDR_W-1:0] src,
        input logic [DATA_W-1:0] rf_data
    );
        if (src == ADDR_W'(ZERO_REG)) begin
            return '0;
        end else if (WbValid && (WbAddr == src)) begin
            return WbData;
        end else begin
            return rf_data;
        end
    endfunction

    assign op_a = pick_operand(InRs, Dout1);
    assign op_b = pick_operand(InRt, Dout2);

    always_comb begin
        valid_d = valid_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        rd_d    = rd_q;
        rdwr_d  = rdwr_q;
        if (accept) begin
            valid_d = 1'b1;
            opa_d   = op_a;
            opb_d   = op_b;
            rd_d    = InRd;
            rdwr_d  = InRdWr;
        end else if (OutReady) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            rd_q    <= '0;
            rdwr_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rd_q    <= rd_d;
            rdwr_q  <= rdwr_d;
        end
    end

    assign OutValid = valid_q;
    assign OutOpA   = opa_q;
    assign OutOpB   = opb_q;
    assign OutRd    = rd_q;
    assign OutRdWr  = rdwr_q;

endmodule : rf_operand_fetch

// File: tb/tb_rf_operand_fetch.sv
// Self-checking bench for rf_operand_fetch: directed scenarios plus a random
// run checked against an architectural model (register array + pending set).
module tb_rf_operand_fetch;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          InValid, InReady;
    logic [AW-1:0] InRs, InRt, InRd;
    logic          InRdWr;
    logic [AW-1:0] Ard1, Ard2;
    logic [DW-1:0] Dout1, Dout2;
    logic          WbValid;
    logic [AW-1:0] WbAddr;
    logic [DW-1:0] WbData;
    logic [AW-1:0] Awr;
    logic [DW-1:0] Din;
    logic          WrEn;
    logic          OutValid, OutReady;
    logic [DW-1:0] OutOpA, OutOpB;
    logic [AW-1:0] OutRd;
    logic          OutRdWr;

    always #5 Clk = ~Clk;

    rf_operand_fetch dut (
        .Clk(Clk), .Reset(Reset),
        .InValid(InValid), .InReady(InReady),
        .InRs(InRs), .InRt(InRt), .InRd(InRd), .InRdWr(InRdWr),
        .Ard1(Ard1), .Ard2(Ard2), .Dout1(Dout1), .Dout2(Dout2),
        .WbValid(WbValid), .WbAddr(WbAddr), .WbData(WbData),
        .Awr(Awr), .Din(Din), .WrEn(WrEn),
        .OutValid(OutValid), .OutReady(OutReady),
        .OutOpA(OutOpA), .OutOpB(OutOpB), .OutRd(OutRd), .OutRdWr(OutRdWr)
    );

    // Register file environment, driven only by the DUT's ports.
    logic [DW-1:0] rf_env [NR];
    assign Dout1 = rf_env[Ard1];
    assign Dout2 = rf_env[Ard2];
    always @(posedge Clk) if (WrEn) rf_env[Awr] <= Din;

    // Architectural model.
    bit            mbusy [NR];
    logic [DW-1:0] arch  [NR];
    logic          mvalid = 1'b0;
    logic [DW-1:0] mopa = '0, mopb = '0;
    logic [AW-1:0] mrd = '0;
    logic          mrdwr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic bit m_pend(input logic [AW-1:0] r);
        return (r != 0) && mbusy[r] && !(WbValid && WbAddr == r);
    endfunction

    function automatic bit m_ready();
        bit hz;
        hz = InValid && (m_pend(InRs) || m_pend(InRt) || (InRdWr && m_pend(InRd)));
        return (!mvalid || OutReady) && !hz && !Reset;
    endfunction

    function automatic logic [DW-1:0] m_opnd(input logic [AW-1:0] r);
        if (r == 0) return '0;
        if (WbValid && WbAddr == r) return WbData;
        return arch[r];
    endfunction

    task automatic drive(input bit iv, input int rs, input int rt, input int rd, input bit rdwr,
                         input bit wbv, input int wba, input logic [DW-1:0] wbd,
                         input bit ordy, input bit rst);
        InValid = iv; InRs = AW'(rs); InRt = AW'(rt); InRd = AW'(rd); InRdWr = rdwr;
        WbValid = wbv; WbAddr = AW'(wba); WbData = wbd;
        OutReady = ordy; Reset = rst;
        #1;
    endtask

    // One clock edge; the model follows the rules using the inputs held across it.
    task automatic advance();
        bit            acc;
        logic [DW-1:0] a, b;
        acc = InValid && m_ready();
        a   = m_opnd(InRs);
        b   = m_opnd(InRt);
        @(posedge Clk);
        if (Reset) begin
            foreach (mbusy[i]) mbusy[i] = 1'b0;
            mvalid = 1'b0; mopa = '0; mopb = '0; mrd = '0; mrdwr = 1'b0;
        end else begin
            if (acc) begin
                mvalid = 1'b1; mopa = a; mopb = b; mrd = InRd; mrdwr = InRdWr;
            end else if (OutReady) begin
                mvalid = 1'b0;
            end
            if (WbValid) begin
                arch[WbAddr]  = WbData;
                mbusy[WbAddr] = 1'b0;
            end
            if (acc && InRdWr && InRd != 0) mbusy[InRd] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, '0, 1, 0);
        advance();
    endtask

    task automatic test_reset();
        drive(1, 3, 4, 6, 1, 1, 5, 32'hDEAD_BEEF, 1, 1);
        n_cmp++; if (WrEn !== 1'b0) begin n_bad++; $display("FAIL reset_wren: got %b want 0", WrEn); end
        n_cmp++; if (InReady !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", InReady); end
        n_cmp++; if ({Ard1, Ard2, Awr, Din} !== {5'd3, 5'd4, 5'd5, 32'hDEAD_BEEF}) begin
            n_bad++; $display("FAIL reset_passthru: got %h %h %h %h", Ard1, Ard2, Awr, Din);
        end
        advance();
        advance();
        n_cmp++; if ({OutValid, OutOpA, OutOpB, OutRd, OutRdWr} !== '0) begin
            n_bad++; $display("FAIL reset_outs: got v=%b a=%h b=%h rd=%0d w=%b want all 0",
                              OutValid, OutOpA, OutOpB, OutRd, OutRdWr);
        end
        drive(0, 0, 0, 0, 0, 0, 0, '0, 1, 0);
        n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready: got %b want 1", InReady); end
    endtask

    task automatic test_writeport();
        for (int r = 1; r < NR; r++) begin
            logic [DW-1:0] d;
            d = (r == 3) ? 32'h0000_1234 : $urandom;
            drive(0, 0, 0, 0, 0, 1, r, d, 1, 0);
            n_cmp++; if ({WrEn, Awr, Din} !== {1'b1, AW'(r), d}) begin
                n_bad++; $display("FAIL wrport_r%0d: got en=%b a=%0d d=%h want 1 %0d %h", r, WrEn, Awr, Din, r, d);
            end
            advance();
        end
    endtask

    task automatic test_basic();
        drive(1, 3, 0, 0, 0, 0, 0, '0, 1, 0);
        n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL basic_ready: got %b want 1", InReady); end
        advance();
        n_cmp++; if ({OutValid, OutOpA, OutOpB} !== {1'b1, 32'h0000_1234, 32'h0}) begin
            n_bad++; $display("FAIL basic_ops: got v=%b a=%h b=%h want 1 00001234 0", OutValid, OutOpA, OutOpB);
        end
        idle();
    endtask

    task automatic test_bypass();
        drive(1, 1, 2, 5, 1, 0, 0, '0, 1, 0);
        advance();
        n_cmp++; if ({OutValid, OutRd, OutRdWr} !== {1'b1, 5'd5, 1'b1}) begin
            n_bad++; $display("FAIL writer_issue: got v=%b rd=%0d w=%b want 1 5 1", OutValid, OutRd, OutRdWr);
        end
        drive(1, 5, 0, 0, 0, 0, 0, '0, 1, 0);
        n_cmp++; if (InReady !== 1'b0) begin n_bad++; $display("FAIL raw_stall: got %b want 0", InReady); end
        advance();
        n_cmp++; if (OutValid !== 1'b0) begin n_bad++; $display("FAIL raw_bubble: got %b want 0", OutValid); end
        drive(1, 5, 0, 0, 0, 1, 5, 32'hCAFE_F00D, 1, 0);
        n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL bypass_ready: got %b want 1", InReady); end
        advance();
        n_cmp++; if ({OutValid, OutOpA} !== {1'b1, 32'hCAFE_F00D}) begin
            n_bad++; $display("FAIL bypass_data: got v=%b a=%h want 1 cafef00d", OutValid, OutOpA);
        end
        drive(1, 2, 5, 0, 0, 0, 0, '0, 1, 0);
        n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL busy5_cleared: got %b want 1", InReady); end
        advance();
        n_cmp++; if ({OutOpA, OutOpB} !== {arch[2], 32'hCAFE_F00D}) begin
            n_bad++; $display("FAIL rf_readback: got a=%h b=%h want %h cafef00d", OutOpA, OutOpB, arch[2]);
        end
        idle();
    endtask

    task automatic test_waw();
        drive(1, 0, 0, 7, 1, 0, 0, '0, 1, 0);
        advance();
        drive(1, 0, 0, 7, 1, 0, 0, '0, 1, 0);
        n_cmp++; if (InReady !== 1'b0) begin n_bad++; $display("FAIL waw_stall: got %b want 0", InReady); end
        advance();
        drive(1, 0, 0, 7, 1, 1, 7, 32'h7777_0001, 1, 0);
        n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL waw_release: got %b want 1", InReady); end
        advance();
        drive(1, 7, 0, 0, 0, 0, 0, '0, 1, 0);
        n_cmp++; if (InReady !== 1'b0) begin n_bad++; $display("FAIL set_wins: got %b want 0", InReady); end
        advance();
        drive(0, 0, 0, 0, 0, 1, 7, 32'h7777_0002, 1, 0);
        advance();
        idle();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] ea, eb;
        ea = arch[10];
        eb = arch[11];
        drive(1, 10, 11, 12, 0, 0, 0, '0, 1, 0);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(1, 13, 14, 15, 0, 0, 0, '0, 0, 0);
            n_cmp++; if (InReady !== 1'b0) begin n_bad++; $display("FAIL bp_ready%0d: got %b want 0", i, InReady); end
            advance();
            n_cmp++; if ({OutValid, OutOpA, OutOpB, OutRd, OutRdWr} !== {1'b1, ea, eb, 5'd12, 1'b0}) begin
                n_bad++; $display("FAIL bp_hold%0d: got v=%b a=%h b=%h rd=%0d want 1 %h %h 12",
                                  i, OutValid, OutOpA, OutOpB, OutRd, ea, eb);
            end
        end
        drive(1, 13, 14, 15, 0, 0, 0, '0, 1, 0);
        n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %b want 1", InReady); end
        advance();
        n_cmp++; if ({OutValid, OutOpA, OutOpB, OutRd} !== {1'b1, arch[13], arch[14], 5'd15}) begin
            n_bad++; $display("FAIL bp_next: got v=%b a=%h b=%h rd=%0d", OutValid, OutOpA, OutOpB, OutRd);
        end
        idle();
    endtask

    task automatic test_zero_reg();
        drive(1, 0, 0, 0, 1, 1, 0, 32'hFFFF_FFFF, 1, 0);
        n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL zero_ready: got %b want 1", InReady); end
        advance();
        n_cmp++; if ({OutOpA, OutOpB} !== 64'h0) begin
            n_bad++; $display("FAIL zero_bypass: got a=%h b=%h want 0 0", OutOpA, OutOpB);
        end
        drive(1, 0, 0, 0, 1, 0, 0, '0, 1, 0);
        n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL zero_never_busy: got %b want 1", InReady); end
        advance();
        n_cmp++; if (OutOpA !== 32'h0) begin n_bad++; $display("FAIL zero_read: got %h want 0", OutOpA); end
        idle();
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 9, 1, 0, 0, '0, 1, 0);
        advance();
        drive(0, 0, 0, 0, 0, 1, 12, 32'h5A5A_1212, 0, 1);
        n_cmp++; if ({WrEn, InReady} !== 2'b00) begin
            n_bad++; $display("FAIL midrst_comb: got wren=%b ready=%b want 0 0", WrEn, InReady);
        end
        advance();
        n_cmp++; if (OutValid !== 1'b0) begin n_bad++; $display("FAIL midrst_flush: got %b want 0", OutValid); end
        drive(1, 9, 12, 9, 1, 0, 0, '0, 1, 0);
        n_cmp++; if (InReady !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_clr: got %b want 1", InReady); end
        advance();
        n_cmp++; if ({OutOpA, OutOpB} !== {arch[9], arch[12]}) begin
            n_bad++; $display("FAIL midrst_nowrite: got a=%h b=%h want %h %h", OutOpA, OutOpB, arch[9], arch[12]);
        end
        drive(0, 0, 0, 0, 0, 1, 9, $urandom, 1, 0);
        advance();
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            logic [DW+3*AW+2:0] exp_c, got_c;
            logic [2*DW+AW+1:0] exp_o, got_o;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 1) != 0, $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
            exp_c = {m_ready(), WbValid && !Reset, InRs, InRt, WbAddr, WbData};
            got_c = {InReady, WrEn, Ard1, Ard2, Awr, Din};
            n_cmp++; if (got_c !== exp_c) begin
                n_bad++; $display("FAIL rand_comb c%0d: got %h want %h", c, got_c, exp_c);
            end
            advance();
            exp_o = {mvalid, mopa, mopb, mrd, mrdwr};
            got_o = {OutValid, OutOpA, OutOpB, OutRd, OutRdWr};
            n_cmp++; if (got_o !== exp_o) begin
                n_bad++; $display("FAIL rand_out c%0d: got %h want %h", c, got_o, exp_o);
            end
        end
    endtask

    initial begin
        foreach (arch[i]) arch[i] = '0;
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        test_reset();
        test_writeport();
        test_basic();
        test_bypass();
        test_waw();
        test_backpressure();
        test_zero_reg();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_rf_operand_fetch

// File: doc/rf_operand_fetch.md
# rf_operand_fetch

Operand-fetch and writeback front end for the 32×32 register file. It acts as the initiator on the register file's two read ports and single write port. It accepts decoded register fields over a valid/ready handshake, drives the read addresses, and bypasses same-cycle writeback data. A busy scoreboard stalls issue on pending writes. Fetched operands are registered into one output stage toward execute.

## Interface
Parameters:
- DATA_W, 32, operand/register width
- ADDR_W, 5, register address width (2**ADDR_W registers, register 0 hardwired zero)

Ports:
- Clk  in  1  clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- InValid  in  1  decoded instruction fields valid
- InReady  out  1  block accepts fields this cycle
- InRs  in  ADDR_W  source register A
- InRt  in  ADDR_W  source register B
- InRd  in  ADDR_W  destination register
- InRdWr  in  1  instruction writes InRd
- Ard1  out  ADDR_W  register file read address 1 (= InRs)
- Ard2  out  ADDR_W  register file read address 2 (= InRt)
- Dout1  in  DATA_W  register file read data 1
- Dout2  in  DATA_W  register file read data 2
- WbValid  in  1  writeback request from downstream
- WbAddr  in  ADDR_W  writeback register
- WbData  in  DATA_W  writeback data
- Awr  out  ADDR_W  register file write address (= WbAddr)
- Din  out  DATA_W  register file write data (= WbData)
- WrEn  out  1  register file write enable (= WbValid & ~Reset)
- OutValid  out  1  operands valid to execute
- OutReady  in  1  execute accepts
- OutOpA, OutOpB  out  DATA_W  fetched operands
- OutRd  out  ADDR_W  destination passed through
- OutRdWr  out  1  destination-write flag passed through

## Operation
- The register file read ports are combinational. Ard1/Ard2 follow InRs/InRt combinationally.
- Write-port outputs are combinational passthroughs. WrEn is forced to 0 while Reset is high.
- Scoreboard: busy[2**ADDR_W-1:1] tracks pending writes; busy[0] reads as 0 permanently.
- clr(r) = WbValid & (WbAddr==r).
- pend(r) = busy[r] & ~clr(r).
- Hazard when InValid and any of these holds:
  - pend(InRs)
  - pend(InRt)
  - InRdWr & pend(InRd) (write-after-write stall)
- InReady = (~OutValid | OutReady) & ~hazard & ~Reset.
- Accept = InValid & InReady.
- Operand A select, in priority order:
  1. InRs==0 → 0
  2. clr(InRs) → WbData
  3. otherwise Dout1
- Operand B uses the same priority with InRt and Dout2.
- Scoreboard update each edge:
  - Clear busy[WbAddr] when WbValid.
  - Then set busy[InRd] when Accept & InRdWr & InRd≠0.
  - Set wins when the set and the clear hit the same register.
- A writeback to a non-busy register still writes the RF; the scoreboard is unchanged and no error is raised.
- Output stage:
  - On Accept, load OutOpA/OutOpB/OutRd/OutRdWr and set OutValid.
  - Else if OutReady, clear OutValid.
  - While OutValid & ~OutReady, all Out* hold stable.

## Timing
- Reset values: OutValid=0, OutOpA=0, OutOpB=0, OutRd=0, OutRdWr=0, busy all 0, InReady=0, WrEn=0.
- Latency is 1 cycle: fields accepted at edge N appear on Out* after edge N.
- Throughput is 1 per cycle when OutReady is held high and there are no hazards.
- Same-cycle writeback of a source register is bypassed with no stall.
- A writeback arriving one or more cycles before issue is read from the RF, which was written at the earlier edge.
- Reset asserted mid-operation:
  - The next edge discards the output stage and clears the scoreboard.
  - Writebacks presented during Reset are not written.
- Out* are registered. InReady and the write-port outputs are combinational from inputs and state.

## Structure
- Shared package rf_pkg holds:
  - DATA_W=32, ADDR_W=5, NUM_REGS=32
  - ZERO_REG=0
- Sub-module rf_scoreboard holds the busy vector:
  - set port and clear port, with set priority
  - three combinational pending lookups with clear exemption
- Top level contains the bypass muxes, handshake logic, and output register.

## Test plan
- Reset then idle: InValid=1, InRs=3, InRt=0, RF r3=0x1234, OutReady=1 → next cycle OutValid=1, OutOpA=0x1234, OutOpB=0.
- Issue writer InRd=5, InRdWr=1, then reader InRs=5 → InReady=0. Apply WbValid, WbAddr=5, WbData=0xCAFEF00D in a stall cycle → accepted that cycle, OutOpA=0xCAFEF00D, busy[5] cleared.
- WAW: busy[7]=1 and InRd=7, InRdWr=1 with no writeback → stall. Apply writeback to 7 in the same cycle → accepted and busy[7] remains 1 (set wins).
- Backpressure: OutValid=1 and OutReady=0 for 3 cycles → InReady=0 and Out* unchanged. OutReady=1 → the next instruction is accepted in that same cycle.
- Writes to register 0: WbValid with WbAddr=0, WbData=0xFFFFFFFF, then InRs=0 → OutOpA=0, and busy is never set for InRd=0.
- Reset mid-stream: assert Reset while OutValid=1, busy[9]=1, WbValid=1 → WrEn=0. After the edge, OutValid=0, busy all 0, and InRs=9 is accepted immediately after Reset falls.
